mips_cpu_mem_arbiter: RTL and testbench

MIPS_CPU_MEM_ARBITER -- requirements
Module: mips_cpu_mem_arbiter

---
 rtl/mips_cpu_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mips_cpu_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_mem_arbiter.sv
// Arbitrates the instruction-fetch and data ports of a MIPS core onto one
// memory port with waitrequest stalls; data wins unless fetch has lost three times in a row.
module mips_cpu_mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        if_read,
  input  logic [31:0] if_address,
  output logic [31:0] if_readdata,
  output logic        if_valid,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_writedata,
  input  logic [3:0]  data_byteenable,
  output logic [31:0] data_readdata,
  output logic        data_valid,
  output logic        data_error,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds its request level until it sees its
  // one-cycle *_valid pulse; the memory completes the access in the first
  // cycle mem_read/mem_write is high with mem_waitrequest low, and the
  // command stays frozen while waitrequest is high.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_IF_ACCESS = 2'd1,
    ST_D_ACCESS  = 2'd2,
    ST_RESP      = 2'd3
  } state_t;

  state_t      state_q;
  logic [1:0]  starve_cnt_q;
  logic [1:0]  starve_cnt_d;
  logic [31:0] if_readdata_q;
  logic        if_valid_q;
  logic [31:0] data_readdata_q;
  logic        data_valid_q;
  logic        data_error_q;
  logic [31:0] mem_address_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] mem_writedata_q;
  logic [3:0]  mem_byteenable_q;
  logic        busy_q;

  logic data_req;
  logic proto_err;
  logic fetch_wins;
  logic grant_fetch;
  logic grant_data;
  logic addr_lsb_unused;

  // Byte lanes travel on the byteenables; word addresses drop bits [1:0].
  assign addr_lsb_unused = ^{if_address[1:0], data_address[1:0]};

  always_comb begin
    data_req     = data_read | data_write;
    proto_err    = data_read & data_write;
    fetch_wins   = if_read & (~data_req | (starve_cnt_q == 2'd3));
    grant_fetch  = ~proto_err & fetch_wins;
    grant_data   = ~proto_err & data_req & ~fetch_wins;
    starve_cnt_d = starve_cnt_q;
    if (!if_read || grant_fetch) begin
      starve_cnt_d = 2'd0;
    end else if (grant_data && starve_cnt_q != 2'd3) begin
      starve_cnt_d = starve_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      starve_cnt_q     <= 2'd0;
      if_readdata_q    <= 32'h0;
      if_valid_q       <= 1'b0;
      data_readdata_q  <= 32'h0;
      data_valid_q     <= 1'b0;
      data_error_q     <= 1'b0;
      mem_address_q    <= 32'h0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_writedata_q  <= 32'h0;
      mem_byteenable_q <= 4'b0000;
      busy_q           <= 1'b0;
    end else if (clk_enable) begin
      data_error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          starve_cnt_q <= starve_cnt_d;
          if (proto_err) begin
            data_error_q <= 1'b1;
          end else if (grant_fetch) begin
            mem_address_q    <= {if_address[31:2], 2'b00};
            mem_read_q       <= 1'b1;
            mem_write_q      <= 1'b0;
            mem_byteenable_q <= 4'b1111;
            busy_q           <= 1'b1;
            state_q          <= ST_IF_ACCESS;
          end else if (grant_data) begin
            mem_address_q    <= {data_address[31:2], 2'b00};
            mem_read_q       <= data_read;
            mem_write_q      <= data_write;
            mem_byteenable_q <= data_byteenable;
            if (data_write) begin
              mem_writedata_q <= data_writedata;
            end
            busy_q  <= 1'b1;
            state_q <= ST_D_ACCESS;
          end
        end
        ST_IF_ACCESS: begin
          if (!mem_waitrequest) begin
            if_readdata_q <= mem_readdata;
            mem_read_q    <= 1'b0;
            if_valid_q    <= 1'b1;
            state_q       <= ST_RESP;
          end
        end
        ST_D_ACCESS: begin
          if (!mem_waitrequest) begin
            // Writes leave the last read word visible to the core.
            if (mem_read_q) begin
              data_readdata_q <= mem_readdata;
            end
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            data_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if_valid_q   <= 1'b0;
          data_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign if_readdata    = if_readdata_q;
  assign if_valid       = if_valid_q;
  assign data_readdata  = data_readdata_q;
  assign data_valid     = data_valid_q;
  assign data_error     = data_error_q;
  assign mem_address    = mem_address_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_writedata  = mem_writedata_q;
  assign mem_byteenable = mem_byteenable_q;
  assign busy           = busy_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Transaction-level bench for mips_cpu_mem_arbiter: directed scenarios then
// randomized requests, each checked against an arbitration/latency model.
module tb_mips_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        if_read;
  logic [31:0] if_address;
  logic [31:0] if_readdata;
  logic        if_valid;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_writedata;
  logic [3:0]  data_byteenable;
  logic [31:0] data_readdata;
  logic        data_valid;
  logic        data_error;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic        busy;
  logic [1:0]  dbg_state;

  // clock / reset block
  always #5 clk = ~clk;

  mips_cpu_mem_arbiter dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .if_read(if_read), .if_address(if_address),
    .if_readdata(if_readdata), .if_valid(if_valid),
    .data_read(data_read), .data_write(data_write),
    .data_address(data_address), .data_writedata(data_writedata),
    .data_byteenable(data_byteenable), .data_readdata(data_readdata),
    .data_valid(data_valid), .data_error(data_error),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
    .busy(busy), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad = 0;

  // reference model: consecutive data wins while fetch waits, last words seen
  int          lost_m = 0;
  logic [31:0] last_if = 32'h0;
  logic [31:0] last_d = 32'h0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_requests();
    if_read    = 1'b0;
    data_read  = 1'b0;
    data_write = 1'b0;
  endtask

  task automatic scramble_requester();
    if_address      = $urandom;
    data_address    = $urandom;
    data_writedata  = $urandom;
    data_byteenable = 4'($urandom_range(0, 15));
    if_read         = 1'($urandom_range(0, 1));
    data_read       = 1'($urandom_range(0, 1));
    data_write      = 1'($urandom_range(0, 1));
  endtask

  task automatic mem_check(input string tag, input logic [31:0] ea, input logic [3:0] ebe,
                           input bit er, input bit ew, input logic [31:0] ewd);
    chk({tag, "_addr"}, mem_address, ea);
    chk({tag, "_rd"}, mem_read, er);
    chk({tag, "_wr"}, mem_write, ew);
    chk({tag, "_be"}, mem_byteenable, ebe);
    if (ew) chk({tag, "_wdata"}, mem_writedata, ewd);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_ivalid"}, if_valid, 0);
    chk({tag, "_dvalid"}, data_valid, 0);
  endtask

  // Driver + checker for one arbitration round, entered at the start of an IDLE cycle.
  task automatic run_txn(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                         input logic [31:0] da, input logic [31:0] wd, input logic [3:0] be,
                         input int waits, input logic [31:0] rd, input int freeze);
    bit          take_f;
    bit          take_d;
    logic [31:0] ea;
    logic [3:0]  ebe;
    logic [31:0] got;
    if_read = ir; if_address = ia;
    data_read = dr; data_write = dw; data_address = da;
    data_writedata = wd; data_byteenable = be;
    if (dr && dw) begin
      tick();
      chk("err_pulse", data_error, 1);
      chk("err_no_rd", mem_read, 0);
      chk("err_no_wr", mem_write, 0);
      chk("err_busy", busy, 0);
      if (!ir) lost_m = 0;
      data_read = 1'b0; data_write = 1'b0;
      return;
    end
    take_f = ir && (!(dr || dw) || lost_m == 3);
    take_d = (dr || dw) && !take_f;
    if (!take_f && !take_d) begin
      lost_m = 0;
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_rd", mem_read, 0);
      chk("idle_wr", mem_write, 0);
      chk("idle_err", data_error, 0);
      return;
    end
    if (take_f) lost_m = 0;
    else lost_m = ir ? ((lost_m < 3) ? lost_m + 1 : 3) : 0;
    ea  = take_f ? {ia[31:2], 2'b00} : {da[31:2], 2'b00};
    ebe = take_f ? 4'hF : be;
    exp_q.push_back((take_f || dr) ? rd : last_d);
    tick();
    chk("grant_err", data_error, 0);
    mem_check("grant", ea, ebe, take_f || dr, take_d && dw, wd);
    scramble_requester();
    for (int i = 0; i < waits; i++) begin
      mem_waitrequest = 1'b1;
      mem_readdata = $urandom;
      tick();
      mem_check("stall", ea, ebe, take_f || dr, take_d && dw, wd);
      scramble_requester();
    end
    mem_waitrequest = 1'b0;
    mem_readdata = rd;
    tick();
    got = exp_q.pop_front();
    chk("resp_ivalid", if_valid, take_f);
    chk("resp_dvalid", data_valid, take_d);
    chk("resp_rd_off", mem_read, 0);
    chk("resp_wr_off", mem_write, 0);
    if (take_f) last_if = got;
    else last_d = got;
    chk("resp_ifdata", if_readdata, last_if);
    chk("resp_ddata", data_readdata, last_d);
    drop_requests();
    mem_readdata = $urandom;
    if (freeze > 0) begin
      clk_enable = 1'b0;
      for (int i = 0; i < freeze; i++) begin
        tick();
        chk("frz_ivalid", if_valid, take_f);
        chk("frz_dvalid", data_valid, take_d);
        chk("frz_busy", busy, 1);
      end
      clk_enable = 1'b1;
    end
    tick();
    chk("back_ivalid", if_valid, 0);
    chk("back_dvalid", data_valid, 0);
    chk("back_busy", busy, 0);
  endtask

  initial begin
    bit          ir;
    bit          dr;
    bit          dw;
    int          kind;
    reset = 1'b1; clk_enable = 1'b1;
    drop_requests();
    if_address = 32'h0; data_address = 32'h0; data_writedata = 32'h0;
    data_byteenable = 4'h0; mem_readdata = 32'h0; mem_waitrequest = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_rd", mem_read, 0);
    chk("rst_wr", mem_write, 0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_wdata", mem_writedata, 32'h0);
    chk("rst_be", mem_byteenable, 4'h0);
    chk("rst_ifdata", if_readdata, 32'h0);
    chk("rst_ddata", data_readdata, 32'h0);
    chk("rst_valid", {if_valid, data_valid, data_error}, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // boot fetch, zero wait states
    run_txn(1, 32'hBFC00000, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h24020005, 0);
    // data beats fetch, then fetch gets the next IDLE
    run_txn(1, 32'hBFC00004, 1, 0, 32'h00001003, 32'h0, 4'hF, 0, 32'h11223344, 0);
    run_txn(1, 32'hBFC00004, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h00000000, 0);
    // stalled write, data_readdata must keep the previous read word
    run_txn(0, 32'h0, 0, 1, 32'h00002002, 32'hDEADBEEF, 4'b0011, 3, 32'hCAFEF00D, 0);
    // fetch starvation limit: the fourth arbitration goes to the fetch
    for (int i = 0; i < 4; i++)
      run_txn(1, 32'hBFC00100, 1, 0, 32'h00003000 + 32'(i * 4), 32'h0, 4'hF, 1, $urandom, 0);
    chk("starve_last_if", if_readdata, last_if);
    // protocol error, fetch stays pending and is granted next
    run_txn(1, 32'hBFC00200, 1, 1, 32'h00004000, 32'h55AA55AA, 4'hF, 0, 32'h0, 0);
    run_txn(1, 32'hBFC00200, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0BADF00D, 0);
    // clock enable freezes a valid pulse in place
    run_txn(0, 32'h0, 1, 0, 32'h00005008, 32'h0, 4'b1100, 1, 32'h87654321, 3);

    // reset in the middle of a stalled read
    data_read = 1'b1; data_address = 32'h00006004; data_byteenable = 4'hF;
    tick();
    mem_waitrequest = 1'b1;
    tick();
    chk("pre_rst_rd", mem_read, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_rd", mem_read, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", mem_address, 32'h0);
    chk("arst_be", mem_byteenable, 4'h0);
    drop_requests();
    lost_m = 0; last_if = 32'h0; last_d = 32'h0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    mem_waitrequest = 1'b0;
    mem_readdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_dvalid", data_valid, 0);
      chk("post_rst_ivalid", if_valid, 0);
      chk("post_rst_busy", busy, 0);
    end
    chk("post_rst_ddata", data_readdata, 32'h0);

    // randomized rounds, fetch requested most of the time to exercise starvation
    for (int n = 0; n < 250; n++) begin
      ir = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 9);
      dr = (kind == 0) || (kind >= 1 && kind <= 3);
      dw = (kind == 0) || (kind >= 4 && kind <= 6);
      run_txn(ir, $urandom, dr, dw, $urandom, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3), $urandom,
              ($urandom_range(0, 7) == 0) ? 2 : 0);
    end

    chk("final_q_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
